frame_seq: RTL and testbench

Parametrised image-sensor capture sequencer running on FSM_Clk.
- Generates the sensor reset pulse, the FIFO reset pulse, a settle delay and the frame-request pulse.
- Runs single-frame, N-frame burst and continuous capture modes. It tracks frame completion by counting line-valid rising edges.
- Sits between the host wire-in endpoints (sensor reset, grab, frame count) and the sensor control pins and capture FIFO reset.

---
 rtl/frame_seq_pkg.sv | 31 +++
 rtl/frame_seq_lval_sync.sv | 31 +++
 rtl/frame_seq.sv | 259 +++++++++++++++++++++++++
 tb/tb_frame_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared state encodings and default timing constants for the frame_seq capture sequencer.
package frame_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SENS_RST   = 3'd1,
        ST_FIFO_RST   = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_FREQ       = 3'd4,
        ST_WAIT_FRAME = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    localparam int DEF_SENSOR_RST_CYC  = 16;
    localparam int DEF_FIFO_RST_CYC    = 4;
    localparam int DEF_SETTLE_CYC      = 17;
    localparam int DEF_FREQ_PULSE_CYC  = 1;
    localparam int DEF_LINES_PER_FRAME = 488;
    localparam int DEF_TIMEOUT_CYC     = 2000000;

    // Width of a shared duration counter able to reach any of the phase lengths.
    function automatic int dur_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1) + 1;
    endfunction

endpackage

// File: rtl/frame_seq_lval_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse; usable for LVAL or DVAL.
module frame_seq_lval_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;

    // Synchronise the asynchronous level and detect its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/frame_seq.sv
// Image-sensor capture sequencer: sensor reset, FIFO reset, settle, frame request and frame counting.
// Optional per-frame timeout with ERROR state enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_seq
    import frame_seq_pkg::*;
#(
    parameter int SENSOR_RST_CYC  = DEF_SENSOR_RST_CYC,
    parameter int FIFO_RST_CYC    = DEF_FIFO_RST_CYC,
    parameter int SETTLE_CYC      = DEF_SETTLE_CYC,
    parameter int FREQ_PULSE_CYC  = DEF_FREQ_PULSE_CYC,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int LINE_W          = 10,
    parameter int CNT_W           = 8,
    parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
    parameter int TMO_W           = 24
) (
    input  logic              FSM_Clk,
    input  logic              sys_res_n,
    input  logic              sensor_rst_req,
    input  logic              grab_start,
    input  logic              mode_continuous,
    input  logic [CNT_W-1:0]  frame_count,
    input  logic              abort,
    input  logic              line_valid_async,
    output logic              sensor_res_n,
    output logic              frame_req,
    output logic              fifo_rst,
    output logic              busy,
    output logic              frame_done,
    output logic              burst_done,
    output logic [CNT_W-1:0]  frames_captured,
    output logic [LINE_W-1:0] lines_seen,
    output logic              error,
    output logic [2:0]        state_o
);

    localparam int DUR_W = dur_width(SENSOR_RST_CYC, FIFO_RST_CYC, SETTLE_CYC, FREQ_PULSE_CYC);

    localparam logic [DUR_W-1:0]  DUR_ZERO   = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0]  DUR_ONE    = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0]  SENS_LAST  = DUR_W'(SENSOR_RST_CYC - 1);
    localparam logic [DUR_W-1:0]  FIFO_LAST  = DUR_W'(FIFO_RST_CYC - 1);
    localparam logic [DUR_W-1:0]  SETL_LAST  = DUR_W'(SETTLE_CYC - 1);
    localparam logic [DUR_W-1:0]  FREQ_LAST  = DUR_W'(FREQ_PULSE_CYC - 1);
    localparam logic [LINE_W-1:0] LINE_ZERO  = {LINE_W{1'b0}};
    localparam logic [LINE_W-1:0] LINE_ONE   = {{(LINE_W-1){1'b0}}, 1'b1};
    localparam logic [LINE_W-1:0] LINE_FULL  = LINE_W'(LINES_PER_FRAME);
    localparam logic [CNT_W-1:0]  CAP_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CAP_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CAP_MAX    = {CNT_W{1'b1}};

    state_t            state_r;
    logic [DUR_W-1:0]  dur_r;
    logic              sens_prev_r;
    logic              grab_prev_r;
    logic              sensor_res_n_r;
    logic              frame_req_r;
    logic              fifo_rst_r;
    logic              busy_r;
    logic              frame_done_r;
    logic              burst_done_r;
    logic [CNT_W-1:0]  frames_captured_r;
    logic [CNT_W-1:0]  target_r;
    logic [LINE_W-1:0] lines_seen_r;
    logic              error_r;

    logic              sens_edge_s;
    logic              grab_edge_s;
    logic              lval_rise_s;
    logic              count_en_s;
    logic              frame_end_s;
    logic [CNT_W-1:0]  cap_inc_s;

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_r;
`else
    logic [TMO_W-1:0] tmo_unused_s;
    assign tmo_unused_s = TMO_W'(TIMEOUT_CYC);
`endif

    frame_seq_lval_sync u_lval_sync (
        .clk   (FSM_Clk),
        .rst_n (sys_res_n),
        .din   (line_valid_async),
        .rise  (lval_rise_s)
    );

    assign sens_edge_s = sensor_rst_req & ~sens_prev_r;
    assign grab_edge_s = grab_start & ~grab_prev_r;
    assign count_en_s  = (state_r == ST_FREQ) || (state_r == ST_WAIT_FRAME);
    assign frame_end_s = (lines_seen_r >= LINE_FULL);
    assign cap_inc_s   = (frames_captured_r == CAP_MAX) ? CAP_MAX : (frames_captured_r + CAP_ONE);

    // Sequencer FSM with registered control outputs, counters and request edge detection.
    always_ff @(posedge FSM_Clk or negedge sys_res_n) begin
        if (!sys_res_n) begin
            state_r           <= ST_IDLE;
            dur_r             <= DUR_ZERO;
            sens_prev_r       <= 1'b0;
            grab_prev_r       <= 1'b0;
            sensor_res_n_r    <= 1'b1;
            frame_req_r       <= 1'b0;
            fifo_rst_r        <= 1'b0;
            busy_r            <= 1'b0;
            frame_done_r      <= 1'b0;
            burst_done_r      <= 1'b0;
            frames_captured_r <= CAP_ZERO;
            target_r          <= CAP_ONE;
            lines_seen_r      <= LINE_ZERO;
            error_r           <= 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
            tmo_r             <= TMO_ZERO;
`endif
        end else begin
            sens_prev_r  <= sensor_rst_req;
            grab_prev_r  <= grab_start;
            frame_done_r <= 1'b0;
            burst_done_r <= 1'b0;

            // Lines past a full frame are dropped so lines_seen never overshoots.
            if (count_en_s && lval_rise_s && (lines_seen_r < LINE_FULL)) begin
                lines_seen_r <= lines_seen_r + LINE_ONE;
            end

            if (abort && busy_r) begin
                state_r        <= ST_IDLE;
                busy_r         <= 1'b0;
                dur_r          <= DUR_ZERO;
                sensor_res_n_r <= 1'b1;
                frame_req_r    <= 1'b0;
                fifo_rst_r     <= 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
                tmo_r          <= TMO_ZERO;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (sens_edge_s) begin
                            state_r        <= ST_SENS_RST;
                            busy_r         <= 1'b1;
                            dur_r          <= DUR_ZERO;
                            sensor_res_n_r <= 1'b0;
                        end else if (grab_edge_s) begin
                            state_r           <= ST_FIFO_RST;
                            busy_r            <= 1'b1;
                            dur_r             <= DUR_ZERO;
                            fifo_rst_r        <= 1'b1;
                            frames_captured_r <= CAP_ZERO;
                            target_r          <= (frame_count == CAP_ZERO) ? CAP_ONE : frame_count;
                        end
                    end
                    ST_SENS_RST: begin
                        if (dur_r == SENS_LAST) begin
                            state_r        <= ST_IDLE;
                            busy_r         <= 1'b0;
                            dur_r          <= DUR_ZERO;
                            sensor_res_n_r <= 1'b1;
                        end else begin
                            dur_r <= dur_r + DUR_ONE;
                        end
                    end
                    ST_FIFO_RST: begin
                        if (dur_r == FIFO_LAST) begin
                            state_r      <= ST_SETTLE;
                            dur_r        <= DUR_ZERO;
                            fifo_rst_r   <= 1'b0;
                            lines_seen_r <= LINE_ZERO;
`ifdef FRAME_SEQ_TIMEOUT_EN
                            tmo_r        <= TMO_ZERO;
`endif
                        end else begin
                            dur_r <= dur_r + DUR_ONE;
                        end
                    end
                    ST_SETTLE: begin
                        if (dur_r == SETL_LAST) begin
                            state_r     <= ST_FREQ;
                            dur_r       <= DUR_ZERO;
                            frame_req_r <= 1'b1;
                        end else begin
                            dur_r <= dur_r + DUR_ONE;
                        end
                    end
                    ST_FREQ: begin
                        if (dur_r == FREQ_LAST) begin
                            state_r     <= ST_WAIT_FRAME;
                            dur_r       <= DUR_ZERO;
                            frame_req_r <= 1'b0;
                        end else begin
                            dur_r <= dur_r + DUR_ONE;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        if (frame_end_s) begin
                            frame_done_r      <= 1'b1;
                            frames_captured_r <= cap_inc_s;
`ifdef FRAME_SEQ_TIMEOUT_EN
                            tmo_r             <= TMO_ZERO;
`endif
                            // Continuous mode is re-evaluated at every frame end.
                            if (!mode_continuous && (cap_inc_s >= target_r)) begin
                                state_r      <= ST_IDLE;
                                busy_r       <= 1'b0;
                                burst_done_r <= 1'b1;
                            end else begin
                                state_r      <= ST_SETTLE;
                                dur_r        <= DUR_ZERO;
                                lines_seen_r <= LINE_ZERO;
                            end
`ifdef FRAME_SEQ_TIMEOUT_EN
                        end else if (tmo_r == TMO_LAST) begin
                            state_r     <= ST_ERROR;
                            busy_r      <= 1'b0;
                            error_r     <= 1'b1;
                            frame_req_r <= 1'b0;
                            tmo_r       <= TMO_ZERO;
                        end else begin
                            tmo_r <= tmo_r + TMO_ONE;
`endif
                        end
                    end
                    ST_ERROR: begin
`ifdef FRAME_SEQ_TIMEOUT_EN
                        if (grab_edge_s || abort) begin
                            state_r <= ST_IDLE;
                            error_r <= 1'b0;
                        end
`else
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
`endif
                    end
                    default: begin
                        state_r        <= ST_IDLE;
                        busy_r         <= 1'b0;
                        dur_r          <= DUR_ZERO;
                        sensor_res_n_r <= 1'b1;
                        frame_req_r    <= 1'b0;
                        fifo_rst_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sensor_res_n    = sensor_res_n_r;
    assign frame_req       = frame_req_r;
    assign fifo_rst        = fifo_rst_r;
    assign busy            = busy_r;
    assign frame_done      = frame_done_r;
    assign burst_done      = burst_done_r;
    assign frames_captured = frames_captured_r;
    assign lines_seen      = lines_seen_r;
    assign error           = error_r;
    assign state_o         = state_r;

endmodule

// File: tb/tb_frame_seq.sv
// Self-checking bench for frame_seq: table-driven bursts, random frame counts and directed corner sequences.
module tb_frame_seq;

    localparam int SRST_CYC = 16;
    localparam int FRST_CYC = 4;
    localparam int SETL_CYC = 17;
    localparam int FREQ_CYC = 1;
    localparam int LPF      = 488;
    localparam int TMO_CYC  = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sensor_rst_req;
    logic       grab_start;
    logic       mode_continuous;
    logic [7:0] frame_count;
    logic       abort;
    logic       line_valid_async;
    logic       sensor_res_n, frame_req, fifo_rst, busy, frame_done, burst_done, error;
    logic [7:0] frames_captured;
    logic [9:0] lines_seen;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic lval_en = 1'b0;

    int n_fdone = 0, n_bdone = 0, n_fifo = 0, n_freq = 0, n_freq_hi = 0;
    int n_srst = 0, n_srst_nobusy = 0;
    logic freq_prev = 1'b0;

    frame_seq #(
        .SENSOR_RST_CYC(SRST_CYC), .FIFO_RST_CYC(FRST_CYC), .SETTLE_CYC(SETL_CYC),
        .FREQ_PULSE_CYC(FREQ_CYC), .LINES_PER_FRAME(LPF), .LINE_W(10), .CNT_W(8),
        .TIMEOUT_CYC(TMO_CYC), .TMO_W(24)
    ) dut (
        .FSM_Clk(clk), .sys_res_n(rst_n), .sensor_rst_req(sensor_rst_req),
        .grab_start(grab_start), .mode_continuous(mode_continuous),
        .frame_count(frame_count), .abort(abort), .line_valid_async(line_valid_async),
        .sensor_res_n(sensor_res_n), .frame_req(frame_req), .fifo_rst(fifo_rst),
        .busy(busy), .frame_done(frame_done), .burst_done(burst_done),
        .frames_captured(frames_captured), .lines_seen(lines_seen), .error(error),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_done) n_fdone <= n_fdone + 1;
        if (burst_done) n_bdone <= n_bdone + 1;
        if (fifo_rst) n_fifo <= n_fifo + 1;
        if (frame_req) n_freq_hi <= n_freq_hi + 1;
        if (frame_req && !freq_prev) n_freq <= n_freq + 1;
        if (!sensor_res_n) n_srst <= n_srst + 1;
        if (!sensor_res_n && !busy) n_srst_nobusy <= n_srst_nobusy + 1;
        freq_prev <= frame_req;
    end

    // Sensor LVAL generator: one-cycle-high pulses with random gaps.
    initial begin
        line_valid_async = 1'b0;
        forever begin
            @(negedge clk);
            if (lval_en) begin
                #2 line_valid_async = 1'b1;
                @(negedge clk);
                #2 line_valid_async = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: number of frames a non-continuous burst should produce.
    function automatic int model_frames(input int fc);
        return (fc == 0) ? 1 : fc;
    endfunction

    task automatic wait_idle(input int bound, input string name);
        int i;
        i = 0;
        while (busy && i < bound) begin
            @(negedge clk);
            i++;
        end
        check({name, "_idle_bound"}, busy, 0);
    endtask

    task automatic wait_freq(input int bound, output int at_cyc, input string name);
        bit seen;
        seen = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (frame_req) begin
                seen = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!seen) check({name, "_freq_bound"}, 0, 1);
    endtask

    task automatic run_burst(input logic [7:0] fc, input int exp_frames, input string name);
        int b_fd, b_bd, b_fq, b_fi, k, r;
        b_fd = n_fdone; b_bd = n_bdone; b_fq = n_freq; b_fi = n_fifo;
        frame_count = fc;
        mode_continuous = 1'b0;
        @(negedge clk);
        grab_start = 1'b1;
        k = cyc + 1;
        wait_freq(80, r, name);
        grab_start = 1'b0;
        frame_count = 8'($urandom_range(0, 255));
        lval_en = 1'b1;
        wait_idle(exp_frames * 3000 + 1000, name);
        lval_en = 1'b0;
        repeat (8) @(negedge clk);
        check({name, "_freq_latency"}, r - k, FRST_CYC + SETL_CYC);
        check({name, "_frame_done"}, n_fdone - b_fd, exp_frames);
        check({name, "_burst_done"}, n_bdone - b_bd, 1);
        check({name, "_freq_pulses"}, n_freq - b_fq, exp_frames);
        check({name, "_fifo_cycles"}, n_fifo - b_fi, FRST_CYC);
        check({name, "_captured"}, frames_captured, exp_frames);
        check({name, "_lines"}, lines_seen, LPF);
        check({name, "_state"}, state_o, 0);
    endtask

    typedef struct {
        logic [7:0] fc;
        int         exp_frames;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int b_fd, b_bd, b_fq, b_fi, b_sr, b_sn, r, fq_hi0;
        vecs[0] = '{8'd1, 1};
        vecs[1] = '{8'd3, 3};
        vecs[2] = '{8'd0, 1};
        vecs[3] = '{8'd2, 2};
        for (int i = 4; i < 6; i++) begin
            vecs[i].fc = 8'($urandom_range(0, 4));
            vecs[i].exp_frames = model_frames(int'(vecs[i].fc));
        end

        rst_n = 1'b0;
        sensor_rst_req = 1'b0; grab_start = 1'b0; mode_continuous = 1'b0;
        frame_count = 8'd1; abort = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_sensor_res_n", sensor_res_n, 1);
        check("rst_outs", {frame_req, fifo_rst, busy, frame_done, burst_done, error}, 0);
        check("rst_counters", {frames_captured, lines_seen}, 0);

        // Sensor reset pulse width, busy throughout.
        b_sr = n_srst; b_sn = n_srst_nobusy;
        sensor_rst_req = 1'b1;
        @(negedge clk);
        check("srst_busy", busy, 1);
        repeat (25) @(negedge clk);
        sensor_rst_req = 1'b0;
        check("srst_low_cycles", n_srst - b_sr, SRST_CYC);
        check("srst_busy_cover", n_srst_nobusy - b_sn, 0);
        check("srst_state", state_o, 0);
        check("srst_released", sensor_res_n, 1);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i].fc, vecs[i].exp_frames, $sformatf("vec%0d", i));
        end
        check("freq_width", n_freq_hi, n_freq * FREQ_CYC);

        // Simultaneous sensor-reset and grab edges: sensor reset wins.
        b_sr = n_srst; b_fi = n_fifo; b_fd = n_fdone;
        @(negedge clk);
        sensor_rst_req = 1'b1; grab_start = 1'b1;
        repeat (25) @(negedge clk);
        check("simul_srst", n_srst - b_sr, SRST_CYC);
        check("simul_no_fifo", n_fifo - b_fi, 0);
        check("simul_state", state_o, 0);
        sensor_rst_req = 1'b0; grab_start = 1'b0;
        repeat (3) @(negedge clk);
        check("simul_no_frame", n_fdone - b_fd, 0);

        // Grab edge while busy is ignored.
        b_fd = n_fdone; b_bd = n_bdone; b_fi = n_fifo;
        frame_count = 8'd2;
        grab_start = 1'b1;
        wait_freq(80, r, "gbusy");
        grab_start = 1'b0;
        lval_en = 1'b1;
        repeat (50) @(negedge clk);
        grab_start = 1'b1;
        repeat (3) @(negedge clk);
        grab_start = 1'b0;
        wait_idle(7000, "gbusy");
        lval_en = 1'b0;
        repeat (8) @(negedge clk);
        check("gbusy_frames", n_fdone - b_fd, 2);
        check("gbusy_bdone", n_bdone - b_bd, 1);
        check("gbusy_fifo", n_fifo - b_fi, FRST_CYC);

        // Continuous mode, cleared during the fifth frame.
        b_fd = n_fdone; b_bd = n_bdone; b_fq = n_freq;
        frame_count = 8'd1;
        mode_continuous = 1'b1;
        grab_start = 1'b1;
        wait_freq(80, r, "cont");
        grab_start = 1'b0;
        lval_en = 1'b1;
        for (int i = 0; i < 20000 && (n_freq - b_fq) < 5; i++) @(negedge clk);
        check("cont_fdone_before_clear", n_fdone - b_fd, 4);
        mode_continuous = 1'b0;
        wait_idle(4000, "cont");
        lval_en = 1'b0;
        repeat (8) @(negedge clk);
        check("cont_frames", n_fdone - b_fd, 5);
        check("cont_bdone", n_bdone - b_bd, 1);
        check("cont_captured", frames_captured, 5);

        // Abort in the middle of WAIT_FRAME.
        b_bd = n_bdone; b_fd = n_fdone;
        frame_count = 8'd3;
        grab_start = 1'b1;
        wait_freq(80, r, "abort");
        grab_start = 1'b0;
        lval_en = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_wait_state", state_o, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        lval_en = 1'b0;
        check("abort_state", state_o, 0);
        check("abort_outs", {busy, frame_req, fifo_rst, ~sensor_res_n}, 0);
        repeat (8) @(negedge clk);
        check("abort_no_bdone", n_bdone - b_bd, 0);
        check("abort_no_fdone", n_fdone - b_fd, 0);
        check("abort_captured", frames_captured, 0);

`ifdef FRAME_SEQ_TIMEOUT_EN
        // Timeout with no LVAL, then recovery by a grab edge.
        frame_count = 8'd1;
        grab_start = 1'b1;
        wait_freq(80, r, "tmo");
        grab_start = 1'b0;
        fq_hi0 = -1;
        for (int i = 0; i < 300 && fq_hi0 < 0; i++) begin
            @(negedge clk);
            if (error) fq_hi0 = cyc;
        end
        check("tmo_latency", fq_hi0 - r, TMO_CYC + 1);
        check("tmo_state", state_o, 6);
        check("tmo_busy", busy, 0);
        @(negedge clk);
        grab_start = 1'b1;
        @(negedge clk);
        check("tmo_clear_err", error, 0);
        check("tmo_clear_state", state_o, 0);
        @(negedge clk);
        check("tmo_no_start", fifo_rst, 0);
        grab_start = 1'b0;
        repeat (3) @(negedge clk);
`else
        fq_hi0 = 0;
        check("no_tmo_error", error, fq_hi0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
